// File: rtl/alu_seq_if.sv
// Handshake bus for alu_seq: operand/op request channel and result/flags response channel.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the response side.
// Signals: in_valid/in_ready/a/b/op (request), out_valid/out_ready/result/carryflag/overflag/zeroflag/out_err (response).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryflag;
  logic             overflag;
  logic             zeroflag;
  logic             out_err;

  // Producer of operations / consumer of results (decode + writeback side).
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carryflag, overflag, zeroflag, out_err
  );

  // The ALU itself.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carryflag, overflag, zeroflag, out_err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: 8 single-cycle ops with carry/overflow/zero flags, iterative SLL/SRL/SRA, illegal-op error.
// Latency: accept at edge N -> out_valid after edge N+1 (shifts: N+1+shamt); one operation in flight.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready is seen at an edge.
// Ports: clk, rst_n (synchronous, active low), s_bus (alu_seq_if.slave: request and response channels).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   s_bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;      // latched operand A; doubles as the shift working register
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_op;
  logic [SHAMT_W-1:0]   r_cnt;    // remaining shift steps
  logic [WIDTH-1:0]     r_res;
  logic                 r_carry;
  logic                 r_over;
  logic                 r_zero;
  logic                 r_err;

  logic                 w_is_sub;
  logic                 w_is_shift;
  logic [WIDTH-1:0]     w_b_opnd;
  logic [WIDTH:0]       w_sum;
  logic                 w_cin_msb;
  logic                 w_ovf;
  logic                 w_lt;
  logic [WIDTH-1:0]     w_res;
  logic                 w_arith;
  logic                 w_legal;
  logic [WIDTH-1:0]     w_shift_nxt;

  // SLT shares the subtractor so its sign/overflow come from the same sum.
  assign w_is_sub   = (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_is_shift = (r_op == OP_SLL) || (r_op == OP_SRL) || (r_op == OP_SRA);
  assign w_b_opnd   = w_is_sub ? ~r_b : r_b;
  assign w_sum      = {1'b0, r_a} + {1'b0, w_b_opnd} + (WIDTH+1)'(w_is_sub);
  // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
  assign w_cin_msb  = w_sum[WIDTH-1] ^ r_a[WIDTH-1] ^ w_b_opnd[WIDTH-1];
  assign w_ovf      = w_cin_msb ^ w_sum[WIDTH];
  assign w_lt       = w_sum[WIDTH-1] ^ w_ovf;

  always_comb begin
    w_shift_nxt = r_a;
    unique case (r_op)
      OP_SLL:  w_shift_nxt = {r_a[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shift_nxt = {1'b0, r_a[WIDTH-1:1]};
      OP_SRA:  w_shift_nxt = {r_a[WIDTH-1], r_a[WIDTH-1:1]};  // MSB never changes, so it stays the original sign
      default: w_shift_nxt = r_a;
    endcase
  end

  always_comb begin
    w_res   = '0;
    w_arith = 1'b0;
    w_legal = 1'b1;
    unique case (r_op)
      OP_ADD, OP_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_arith = 1'b1;
      end
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_AND:  w_res = r_a & r_b;
      OP_NAND: w_res = ~(r_a & r_b);
      OP_NOR:  w_res = ~(r_a | r_b);
      OP_OR:   w_res = r_a | r_b;
      // Shifts finish with the working register once the counter has run out.
      OP_SLL, OP_SRL, OP_SRA: w_res = r_a;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_over  <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (s_bus.in_valid) begin
            r_a     <= s_bus.a;
            r_b     <= s_bus.b;
            r_op    <= s_bus.op;
            r_cnt   <= s_bus.b[SHAMT_W-1:0];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_shift && (r_cnt != '0)) begin
            r_a   <= w_shift_nxt;
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_res   <= w_res;
            r_carry <= w_arith & w_sum[WIDTH];
            r_over  <= w_arith & w_ovf;
            r_zero  <= w_legal & (w_res == '0);
            r_err   <= ~w_legal;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (s_bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign s_bus.out_valid = (r_state == S_DONE);
  assign s_bus.result    = r_res;
  assign s_bus.carryflag = r_carry;
  assign s_bus.overflag  = r_over;
  assign s_bus.zeroflag  = r_zero;
  assign s_bus.out_err   = r_err;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        e;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic bp_mode = 1'b0;
  logic dir_rdy = 1'b1;
  logic rnd_rdy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 2) != 0);
  end
  assign bus.out_ready = bp_mode ? rnd_rdy : dir_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        x;
    logic [32:0] s;
    int          sh;
    x     = '0;
    x.lat = 1;
    sh    = int'(b[4:0]);
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        x.res = s[31:0]; x.c = s[32];
        x.o = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        x.res = s[31:0]; x.c = s[32];
        x.o = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'd2:  x.res = a ^ b;
      4'd3:  x.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  x.res = a & b;
      4'd5:  x.res = ~(a & b);
      4'd6:  x.res = ~(a | b);
      4'd7:  x.res = a | b;
      4'd8:  begin x.res = a << sh; x.lat = 1 + sh; end
      4'd9:  begin x.res = a >> sh; x.lat = 1 + sh; end
      4'd10: begin x.res = $signed(a) >>> sh; x.lat = 1 + sh; end
      default: x.e = 1'b1;
    endcase
    x.z = !x.e && (x.res == 32'd0);
    return x;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 300) begin
      @(posedge clk); #1; k++;
    end
    if (!bus.in_ready) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.out_valid && k < 60) begin
      @(posedge clk); #1; k++;
    end
    if (!bus.out_valid) check("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, output int acc);
    exp_t x;
    wait_ready();
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    x = model(a, b, op);
    x.acc = acc;
    q.push_back(x);
  endtask

  task automatic drain_all();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_v && !prev_r && !bus.out_valid)
          check("out_valid_dropped", {31'd0, bus.out_valid}, 32'd1);
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
          end else begin
            if (!prev_v) check("latency", cyc - q[0].acc, q[0].lat);
            check("result",    bus.result,           q[0].res);
            check("carryflag", {31'd0, bus.carryflag}, {31'd0, q[0].c});
            check("overflag",  {31'd0, bus.overflag},  {31'd0, q[0].o});
            check("zeroflag",  {31'd0, bus.zeroflag},  {31'd0, q[0].z});
            check("out_err",   {31'd0, bus.out_err},   {31'd0, q[0].e});
            if (bus.out_ready) void'(q.pop_front());
          end
        end
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [31:0] pool [6];
    pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h7FFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h0000_0001; pool[5] = 32'hC838_0861;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    bus.result,             32'd0);
    check("rst_flags", {28'd0, bus.carryflag, bus.overflag, bus.zeroflag, bus.out_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed arithmetic and compare cases.
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd0, acc);
    do_op(32'hC838_0861, 32'hC838_0861, 4'd1, acc);
    do_op(32'h0000_0000, 32'h0000_0001, 4'd1, acc);
    do_op(32'h0000_F000, 32'h0000_F001, 4'd3, acc);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 4'd3, acc);
    do_op(32'h5555_5555, 32'hAAAA_AAAA, 4'd3, acc);
    drain_all();

    // SRA by 4 with a rejected in_valid pulse while shifting.
    do_op(32'h8000_0010, 32'h0000_0024, 4'd10, acc);
    for (int i = 0; i < 3; i++) begin
      check("in_ready_mid_shift", {31'd0, bus.in_ready}, 32'd0);
      bus.a = 32'd5; bus.b = 32'd6; bus.op = 4'd0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    wait_valid();
    check("sra_cycles", cyc - acc, 32'd5);
    check("sra_result", bus.result, 32'hF800_0001);
    drain_all();
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: result held for three cycles, then drained.
    dir_rdy = 1'b0;
    do_op(32'd1, 32'd2, 4'd0, acc);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_result",    bus.result,             32'd3);
      @(posedge clk); #1;
    end
    dir_rdy = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_drain", {31'd0, bus.in_ready}, 32'd1);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 4'hC, acc);
    drain_all();

    // Reset in the middle of a long shift discards the operation.
    do_op(32'h0000_0001, 32'd31, 4'd8, acc);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("in_ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_result",    bus.result,             32'd0);
      check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("in_ready_post_rst", {31'd0, bus.in_ready}, 32'd1);
    do_op(32'd0, 32'd0, 4'd0, acc);
    drain_all();

    // Randomised operations with random consumer backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 4) == 0) rb = ra;
      do_op(ra, rb, 4'($urandom_range(0, 15)), acc);
    end
    drain_all();
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Width set by WIDTH.
- Keeps the 8 base operations (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR) with carry/overflow/zero flags.
- Adds iterative multi-cycle shifts (SLL/SRL/SRA) and illegal-op reporting.
- Sits between the instruction decode stage and writeback; valid/ready on both sides; one operation in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), derived localparam; shift-amount width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  unit can accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount for shift ops
- op  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- carryflag  output  1  adder carry-out (ADD/SUB only)
- overflag  output  1  signed overflow (ADD/SUB only)
- zeroflag  output  1  result == 0
- out_err  output  1  illegal op

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
  - 8 SLL, 9 SRL, 10 SRA
  - 11-15 illegal
- FSM states: IDLE, EXEC, DONE.
- in_ready = 1 only in IDLE with rst_n high; it is 0 while rst_n is low.
- Accept: on a clock edge with in_valid & in_ready, latch a, b and op; load the shift counter with b[SHAMT_W-1:0]; go to EXEC. in_valid outside IDLE is ignored.
- EXEC, ops 0-7 and illegal: compute in one cycle, register result and flags, go to DONE.
  - Accept at edge N gives out_valid high after edge N+1.
- EXEC, shifts: shift the working register one bit per cycle and decrement the counter; when the counter is 0, register the result and go to DONE.
  - out_valid rises after edge N+1+shamt; shamt = 0 returns a after edge N+1.
  - SLL and SRL fill with 0; SRA fills with the latched a[WIDTH-1].
  - b bits above SHAMT_W-1 are ignored.
- DONE: out_valid = 1; result and all flags held stable regardless of input changes. An edge with out_ready = 1 returns to IDLE, so in_ready is high the next cycle. No accept occurs in the same cycle as the drain.
- Arithmetic: WIDTH+1-bit sum.
  - ADD: a + b.
  - SUB: a + ~b + 1.
  - carryflag = bit WIDTH of the sum; SUB carry = 1 means no borrow.
  - overflag = carry into MSB XOR carry out of MSB.
  - carryflag and overflag are 0 for every op other than ADD/SUB.
- SLT: result = {0..., (signed a < signed b)}, taken from the SUB sign XOR SUB overflow; carryflag and overflag are 0.
- zeroflag = (result == 0) for all legal ops.
- Illegal op: result = 0, out_err = 1, zeroflag = 0, carry/over = 0; latency as for ops 0-7.
- Reset:
  - rst_n low at any edge forces IDLE and clears the counter.
  - Output values: out_valid 0, result 0, all flags 0, out_err 0.
  - An operation in flight mid-EXEC/DONE is discarded without an out_valid pulse.
  - in_ready is low during reset and high from the first cycle rst_n is high.
- out_valid/out_ready: once out_valid is asserted, it must not deassert until the result is taken.

Test Plan:
1. ADD, a=0x7FFFFFFF, b=0x7FFFFFFF, accept at edge N -> out_valid after N+1; result 0xFFFFFFFE, carry 0, over 1, zero 0.
2. SUB with a=b=0xC8380861 -> result 0, carry 1, over 0, zero 1. SUB with a=0, b=1 -> result 0xFFFFFFFF, carry 0, over 0.
3. SLT:
   - a=0x0000F000, b=0x0000F001 -> result 1.
   - a=0xFFFFFFFF, b=0x00000001 -> result 1.
   - a=0x55555555, b=0xAAAAAAAA -> result 0.
   - All three: carry 0, over 0.
4. SRA a=0x80000010, b=0x00000024 (shamt 4) -> result 0xF8000001 after edge N+5; in_ready 0 throughout; an in_valid pulse mid-shift is not accepted.
5. Backpressure: ADD 1+2 with out_ready held 0 for 3 cycles -> result 3 stable, out_valid held, in_ready 0; out_ready=1 -> in_ready 1 the next cycle. Op 4'hC -> out_err 1, result 0.
6. Reset mid-operation: SLL by 31 with rst_n low 10 cycles after accept -> out_valid 0, result 0, in_ready 0 during reset; after release, ADD 0+0 -> result 0, zero 1 with normal latency.
